// File: rtl/mem_access_if.sv
// Data-bus bundle between the MEM-stage access unit (master) and the data SRAM port (slave).
// Single-outstanding request/response with separate address and data handshakes.
interface mem_access_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access.sv
// MEM-stage data-memory access unit: issues one bus transaction per load/store, stalls the
// pipeline until it completes, then holds the aligned/extended result until MEM/WB captures it.
module mem_access (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         stall,
  input  logic               i_write_mem,
  input  logic               i_mem_to_regfile,
  input  logic               i_write_regfile,
  input  logic [4:0]         i_rn,
  input  logic [31:0]        i_da,
  input  logic [31:0]        i_db,
  input  logic [7:0]         i_mem_control,
  mem_access_if.master       bus,
  output logic               o_stallreq,
  output logic               o_addr_err,
  output logic               o_write_regfile,
  output logic [4:0]         o_rn,
  output logic [31:0]        o_result
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] rbuf_q, rbuf_d;

  logic        is_load;
  logic        op;
  logic        misaligned;
  logic        aligned_op;
  logic        req;
  logic [1:0]  size;
  logic [3:0]  strb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  logic unused_ok;
  assign unused_ok = ^{stall[5], stall[3:0], i_mem_control[7:3]};

  // Store takes priority when both commands are set.
  assign is_load    = i_mem_to_regfile & ~i_write_mem;
  assign op         = i_write_mem | i_mem_to_regfile;
  assign size       = (i_mem_control[1:0] == 2'b11) ? 2'b10 : i_mem_control[1:0];
  assign misaligned = ((size == 2'b10) && (i_da[1:0] != 2'b00)) ||
                      ((size == 2'b01) && i_da[0]);
  assign aligned_op = op & ~misaligned;

  always_comb begin
    state_d = state_q;
    rbuf_d  = rbuf_q;
    req     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (aligned_op) begin
          req     = 1'b1;
          state_d = bus.data_addr_ok ? StWait : StReq;
        end
      end
      StReq: begin
        req = 1'b1;
        if (bus.data_addr_ok) state_d = StWait;
      end
      StWait: begin
        if (bus.data_data_ok) begin
          if (is_load) rbuf_d = bus.data_rdata;
          state_d = StDone;
        end
      end
      StDone: begin
        if (!stall[4]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      rbuf_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      rbuf_q  <= rbuf_d;
    end
  end

  always_comb begin
    strb = 4'b1111;
    unique case (size)
      2'b00:   strb = 4'b0001 << i_da[1:0];
      2'b01:   strb = i_da[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  // Bus is held idle while reset is asserted so a pending op only reissues after release.
  assign bus.data_req   = req & reset;
  assign bus.data_wr    = i_write_mem;
  assign bus.data_size  = size;
  assign bus.data_addr  = i_da;
  assign bus.data_wstrb = i_write_mem ? strb : 4'b0000;

  always_comb begin
    bus.data_wdata = i_db;
    unique case (size)
      2'b00:   bus.data_wdata = {4{i_db[7:0]}};
      2'b01:   bus.data_wdata = {2{i_db[15:0]}};
      default: bus.data_wdata = i_db;
    endcase
  end

  assign ld_byte = rbuf_q[{i_da[1:0], 3'b000} +: 8];
  assign ld_half = rbuf_q[{i_da[1], 4'b0000} +: 16];

  always_comb begin
    ld_val = rbuf_q;
    unique case (size)
      2'b00:   ld_val = i_mem_control[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = i_mem_control[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_val = rbuf_q;
    endcase
  end

  assign o_stallreq      = aligned_op & (state_q != StDone);
  assign o_addr_err      = op & misaligned;
  assign o_write_regfile = i_write_regfile & ~o_addr_err;
  assign o_rn            = i_rn;
  assign o_result        = is_load ? ld_val : i_da;

endmodule
